// File: rtl/noc_ni_defs.sv
// Shared NoC network-interface definitions: flit type codes, read-controller
// FSM state encoding, default flit width and a flit classification helper.
package noc_ni_defs;

   localparam int         FLIT_W    = 16;
   localparam logic [2:0] FLIT_HEAD = 3'b001;
   localparam logic [2:0] FLIT_TAIL = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      CHECK = 2'd2,
      SEND  = 2'd3
   } rdctrl_state_e;

   typedef enum logic [1:0] {
      KIND_HEAD,
      KIND_TAIL,
      KIND_ILLEGAL
   } flit_kind_e;

   function automatic flit_kind_e flit_kind(input logic [2:0] code);
      case (code)
         FLIT_HEAD: return KIND_HEAD;
         FLIT_TAIL: return KIND_TAIL;
         default:   return KIND_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Saturating credit counter for the router local input buffer: loads CREDITS on
// reset, decrements per flit sent, increments per returned credit.
module ni_credit_counter #(
   parameter int CREDITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic dec,
   input  logic inc,
   output logic zero
);

   localparam logic [3:0] MAX_CREDITS = 4'(CREDITS);

   logic [3:0] credits;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of block evaluation order.
      if (rst) begin
         credits <= MAX_CREDITS;
      end else begin
         case ({dec, inc})
            2'b10:   if (credits != 4'd0) credits <= credits - 4'd1;
            2'b01:   if (credits < MAX_CREDITS) credits <= credits + 4'd1;
            default: ;
         endcase
      end
   end

   assign zero = (credits == 4'd0);

endmodule

// File: rtl/priority_ni_fifo_rdctrl.sv
// Drains the priority NI FIFO into the router local port with credit flow control
// and head/tail framing checks. Define PRIO_RDCTRL_STATS_EN for packet/error counters.
module priority_ni_fifo_rdctrl #(
   parameter int CREDITS = 4,
   parameter int FLIT_W  = noc_ni_defs::FLIT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   output logic              fifo_rd,
   input  logic [FLIT_W-1:0] fifo_data,
   output logic [FLIT_W-1:0] flit_out,
   output logic              flit_valid,
   input  logic              credit_ret,
   output logic              pkt_done,
   output logic              frame_err,
   output logic [15:0]       pkt_cnt,
   output logic [7:0]        err_cnt
);

   import noc_ni_defs::*;

   rdctrl_state_e     state_q, state_d;
   logic [FLIT_W-1:0] flit_reg;
   logic              in_pkt, in_pkt_d;
   logic              send_tail;
   logic              send_go;
   logic              credits_zero;
   flit_kind_e        kind;

   assign kind = flit_kind(flit_reg[FLIT_W-1 -: 3]);

   ni_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk  (clk),
      .rst  (rst),
      .dec  (flit_valid),
      .inc  (credit_ret),
      .zero (credits_zero)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      in_pkt_d   = in_pkt;
      fifo_rd    = 1'b0;
      flit_valid = 1'b0;
      pkt_done   = 1'b0;
      frame_err  = 1'b0;
      send_go    = 1'b0;
      case (state_q)
         IDLE: begin
            // A read strobe during reset would pop a flit the FSM never captures.
            if (!fifo_empty && !credits_zero) begin
               fifo_rd = !rst;
               state_d = FETCH;
            end
         end
         FETCH: state_d = CHECK;
         CHECK: begin
            case (kind)
               KIND_HEAD: begin
                  frame_err = in_pkt;
                  in_pkt_d  = 1'b1;
                  send_go   = 1'b1;
                  state_d   = SEND;
               end
               KIND_TAIL: begin
                  if (in_pkt) begin
                     in_pkt_d = 1'b0;
                     send_go  = 1'b1;
                     state_d  = SEND;
                  end else begin
                     frame_err = 1'b1;
                     state_d   = IDLE;
                  end
               end
               default: begin
                  frame_err = 1'b1;
                  state_d   = IDLE;
               end
            endcase
         end
         SEND: begin
            flit_valid = 1'b1;
            pkt_done   = send_tail;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         in_pkt    <= 1'b0;
         flit_reg  <= '0;
         flit_out  <= '0;
         send_tail <= 1'b0;
      end else begin
         state_q <= state_d;
         in_pkt  <= in_pkt_d;
         if (state_q == FETCH) flit_reg <= fifo_data;
         // flit_out only moves when a flit is committed, so it holds between sends.
         if (send_go) begin
            flit_out  <= flit_reg;
            send_tail <= (kind == KIND_TAIL);
         end
      end
   end

`ifdef PRIO_RDCTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
         if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_priority_ni_fifo_rdctrl.sv
// Self-checking bench for priority_ni_fifo_rdctrl: a FIFO model feeds the DUT and a
// packet-level model predicts flits, framing errors, credits and read strobes.
module tb_priority_ni_fifo_rdctrl;

   localparam int CREDITS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [15:0] fifo_data = '0;
   logic [15:0] flit_out;
   logic        flit_valid;
   logic        credit_ret = 1'b0;
   logic        pkt_done;
   logic        frame_err;
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   priority_ni_fifo_rdctrl #(
      .CREDITS (CREDITS),
      .FLIT_W  (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .credit_ret (credit_ret),
      .pkt_done   (pkt_done),
      .frame_err  (frame_err),
      .pkt_cnt    (pkt_cnt),
      .err_cnt    (err_cnt)
   );

   // FIFO: data appears on fifo_data the cycle after a read strobe.
   logic [15:0] fifo_mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd && !fifo_empty) begin
         fifo_data <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Packet-level model: future output events indexed by cycles ahead.
   typedef struct {
      bit          valid;
      bit          err;
      bit          done;
      logic [15:0] data;
   } slot_t;

   slot_t       ahead [0:3];
   int          m_credits, m_busy, exp_pkt, exp_err;
   bit          m_in_pkt;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] obs_q [$];
   int          obs_done = 0;
   int          obs_err  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) ahead[i] = '{default: 0};
      m_credits = CREDITS;
      m_busy    = 0;
      m_in_pkt  = 1'b0;
      exp_pkt   = 0;
      exp_err   = 0;
   endtask

   task automatic model_step();
      slot_t       now;
      bit          exp_rd, send, err, done;
      logic [15:0] f;
      if (rst) begin
         check("fifo_rd_in_reset", 32'(fifo_rd), 0);
         model_reset();
         return;
      end
      now    = ahead[0];
      exp_rd = (m_busy == 0) && !fifo_empty && (m_credits != 0);
      check("flit_valid", 32'(flit_valid), 32'(now.valid));
      if (now.valid) check("flit_out", 32'(flit_out), 32'(now.data));
      check("pkt_done", 32'(pkt_done), 32'(now.done));
      check("frame_err", 32'(frame_err), 32'(now.err));
      check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
      check("credits", 32'(dut.u_credit.credits), m_credits);
`ifdef PRIO_RDCTRL_STATS_EN
      check("pkt_cnt", 32'(pkt_cnt), exp_pkt & 16'hFFFF);
      check("err_cnt", 32'(err_cnt), exp_err);
`else
      check("pkt_cnt", 32'(pkt_cnt), 0);
      check("err_cnt", 32'(err_cnt), 0);
`endif
      if (flit_valid) obs_q.push_back(flit_out);
      if (pkt_done)   obs_done++;
      if (frame_err)  obs_err++;
      if (now.done) exp_pkt++;
      if (now.err && exp_err < 255) exp_err++;
      if (now.valid && !credit_ret) m_credits--;
      else if (credit_ret && !now.valid && m_credits < CREDITS) m_credits++;
      for (int i = 0; i < 3; i++) ahead[i] = ahead[i+1];
      ahead[3] = '{default: 0};
      if (m_busy > 0) m_busy--;
      if (fifo_rd && !fifo_empty) begin
         f    = fifo_mem[rd_ptr];
         send = 1'b0; err = 1'b0; done = 1'b0;
         if (f[15:13] == 3'b001) begin
            err = m_in_pkt; send = 1'b1; m_in_pkt = 1'b1;
         end else if (f[15:13] == 3'b110 && m_in_pkt) begin
            send = 1'b1; done = 1'b1; m_in_pkt = 1'b0;
         end else begin
            err = 1'b1;
         end
         // Classification two cycles after the strobe, send three cycles after.
         ahead[1].err   = err;
         ahead[2].valid = send;
         ahead[2].done  = done;
         ahead[2].data  = f;
         m_busy = send ? 3 : 2;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] f);
      fifo_mem[wr_ptr] = f;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic pulse_credit();
      credit_ret = 1'b1;
      cycle();
      credit_ret = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   function automatic logic [15:0] obs_at(input int i);
      if (i < obs_q.size()) return obs_q[i];
      return 16'hxxxx;
   endfunction

   int base, d_done, d_err, rd0;
   bit hit;

   initial begin
      model_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      check("rst_flit_valid", 32'(flit_valid), 0);
      check("rst_flit_out", 32'(flit_out), 0);
      check("rst_pkt_done", 32'(pkt_done), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_fifo_rd", 32'(fifo_rd), 0);
      check("rst_credits", 32'(dut.u_credit.credits), 4);
      check("rst_pkt_cnt", 32'(pkt_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);

      // 1: one well-formed packet
      base = obs_q.size(); d_done = obs_done;
      push(16'h2059); push(16'hC000);
      repeat (12) cycle();
      check("t1_flits", obs_q.size() - base, 2);
      check("t1_head", 32'(obs_at(base)), 32'h2059);
      check("t1_tail", 32'(obs_at(base + 1)), 32'hC000);
      check("t1_pkt_done", obs_done - d_done, 1);
      check("t1_credits", 32'(dut.u_credit.credits), 2);
`ifdef PRIO_RDCTRL_STATS_EN
      check("t1_pkt_cnt", 32'(pkt_cnt), 1);
`else
      check("t1_pkt_cnt", 32'(pkt_cnt), 0);
`endif

      // 2: credit exhaustion stalls fetching until a credit returns
      do_reset();
      base = obs_q.size(); d_done = obs_done;
      push(16'h2059); push(16'hC000); push(16'h2053);
      push(16'hC000); push(16'h2041); push(16'hC000);
      repeat (24) cycle();
      check("t2_flits_at_zero_credit", obs_q.size() - base, 4);
      check("t2_fifo_rd_blocked", 32'(fifo_rd), 0);
      pulse_credit();
      hit = 1'b0;
      for (int i = 0; i < 4 && !hit; i++) begin
         cycle();
         if (obs_q.size() - base == 5) hit = 1'b1;
      end
      check("t2_fifth_within_4", 32'(hit), 1);
      check("t2_fifth_data", 32'(obs_at(base + 4)), 32'h2041);
      pulse_credit();
      repeat (6) cycle();
      check("t2_flits_total", obs_q.size() - base, 6);
      check("t2_sixth_data", 32'(obs_at(base + 5)), 32'hC000);
      check("t2_pkt_done", obs_done - d_done, 3);

      // 3: orphan tail and illegal type are dropped
      do_reset();
      base = obs_q.size(); d_err = obs_err;
      push(16'hC000);
      repeat (6) cycle();
      check("t3_tail_flits", obs_q.size() - base, 0);
      check("t3_tail_err", obs_err - d_err, 1);
      check("t3_tail_in_pkt", 32'(dut.in_pkt), 0);
      push(16'hE000);
      repeat (6) cycle();
      check("t3_ill_flits", obs_q.size() - base, 0);
      check("t3_ill_err", obs_err - d_err, 2);
      check("t3_ill_in_pkt", 32'(dut.in_pkt), 0);
      check("t3_credits", 32'(dut.u_credit.credits), 4);

      // 4: head interrupting an open packet
      base = obs_q.size(); d_err = obs_err; d_done = obs_done;
      push(16'h2059); push(16'h2053); push(16'hC000);
      repeat (16) cycle();
      check("t4_flits", obs_q.size() - base, 3);
      check("t4_f0", 32'(obs_at(base)), 32'h2059);
      check("t4_f1", 32'(obs_at(base + 1)), 32'h2053);
      check("t4_f2", 32'(obs_at(base + 2)), 32'hC000);
      check("t4_err", obs_err - d_err, 1);
      check("t4_pkt_done", obs_done - d_done, 1);
      check("t4_credits", 32'(dut.u_credit.credits), 1);

      // 5: credit return coincident with send, and saturation at CREDITS
      do_reset();
      base = obs_q.size();
      push(16'h2059); push(16'hC000); push(16'h2059);
      repeat (14) cycle();
      check("t5_credits_before", 32'(dut.u_credit.credits), 1);
      push(16'hC000);
      hit = 1'b0;
      for (int i = 0; i < 8 && !hit; i++) begin
         if (ahead[0].valid) begin
            pulse_credit();
            hit = 1'b1;
         end else begin
            cycle();
         end
      end
      cycle();
      check("t5_coincident_seen", 32'(hit), 1);
      check("t5_credits_after", 32'(dut.u_credit.credits), 1);
      check("t5_flits", obs_q.size() - base, 4);
      repeat (3) pulse_credit();
      cycle();
      check("t5_credits_full", 32'(dut.u_credit.credits), 4);
      pulse_credit();
      cycle();
      check("t5_credits_saturate", 32'(dut.u_credit.credits), 4);

      // 6: reset while a fetched flit sits in CHECK
      do_reset();
      base = obs_q.size();
      push(16'h2059);
      cycle();
      cycle();
      rd0 = rd_ptr;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_flit_valid", 32'(flit_valid), 0);
      check("t6_flit_out", 32'(flit_out), 0);
      check("t6_pkt_done", 32'(pkt_done), 0);
      check("t6_frame_err", 32'(frame_err), 0);
      check("t6_fifo_rd", 32'(fifo_rd), 0);
      check("t6_credits", 32'(dut.u_credit.credits), 4);
      check("t6_in_pkt", 32'(dut.in_pkt), 0);
      check("t6_pkt_cnt", 32'(pkt_cnt), 0);
      check("t6_err_cnt", 32'(err_cnt), 0);
      repeat (6) cycle();
      check("t6_discarded", obs_q.size() - base, 0);
      check("t6_no_reread", rd_ptr - rd0, 0);
      check("t6_popped_once", rd0, wr_ptr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
